mips_bus_sequencer: RTL and testbench

Multi-cycle bus front-end between the single-cycle MIPS core (separate instruction and data ports) and one unified Avalon-style memory-mapped bus with waitrequest.
- Serialises each instruction into fetch, execute, optional memory access and commit.
- Holds the fetched instruction stable for the core and performs byte-lane/endian conversion.
- Emits a one-cycle commit strobe that the core uses to advance its PC and register file.
- Detects halt (PC == HALT_ADDR) and counts retired instructions.

---
 rtl/mips_bus_pkg.sv | 9 +
 rtl/mips_bus_sequencer_byte_lane_swap.sv | 22 ++
 rtl/mips_bus_sequencer.sv | 146 ++++++++++++++
 tb/tb_mips_bus_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus sequencer.
package mips_bus_pkg;
    typedef enum logic [2:0] {FETCH, EXEC, MEM, COMMIT, HALTED} state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES = DATA_W_DEFAULT / 8;
    localparam int OFFSET_W = $clog2(BYTES);
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/mips_bus_sequencer_byte_lane_swap.sv
// Byte-lane reversal between the big-endian core and little-endian bus; pass-through when disabled.
module byte_lane_swap
    import mips_bus_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int SWAP_LANES = 1
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int N = DATA_W / 8;

    generate
        if (SWAP_LANES != 0) begin : g_swap
            for (genvar i = 0; i < N; i++) begin : g_lane
                assign dout[8*i +: 8] = din[8*(N-1-i) +: 8];
            end
        end else begin : g_pass
            assign dout = din;
        end
    endgenerate
endmodule

// File: rtl/mips_bus_sequencer.sv
// Multi-cycle front-end serialising a single-cycle MIPS core onto one Avalon-MM bus.
module mips_bus_sequencer
    import mips_bus_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(HALT_ADDR_DEFAULT),
    parameter int                SWAP_LANES = 1,
    parameter int                PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic [ADDR_W-1:0]     core_pc,
    output logic [DATA_W-1:0]     core_instr,
    input  logic [ADDR_W-1:0]     core_data_address,
    input  logic                  core_data_read,
    input  logic                  core_data_write,
    input  logic [DATA_W/8-1:0]   core_byteenable,
    input  logic [DATA_W-1:0]     core_writedata,
    output logic [DATA_W-1:0]     core_readdata,
    output logic                  core_step,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata,
    input  logic                  waitrequest,
    output logic                  active,
    output logic [PERF_W-1:0]     retired
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BE_W - 1));

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [PERF_W-1:0]   retired_q, retired_d;

    logic [DATA_W-1:0]   instr_sw, load_sw, wdata_sw;
    logic [BE_W-1:0]     be_conv;

    byte_lane_swap #(.DATA_W(DATA_W), .SWAP_LANES(SWAP_LANES)) u_swap_instr (
        .din  (readdata),
        .dout (instr_sw)
    );

    byte_lane_swap #(.DATA_W(DATA_W), .SWAP_LANES(SWAP_LANES)) u_swap_load (
        .din  (readdata),
        .dout (load_sw)
    );

    byte_lane_swap #(.DATA_W(DATA_W), .SWAP_LANES(SWAP_LANES)) u_swap_wdata (
        .din  (core_writedata),
        .dout (wdata_sw)
    );

    always_comb begin
        be_conv = core_byteenable;
        if (SWAP_LANES != 0) begin
            for (int i = 0; i < BE_W; i++) begin
                be_conv[i] = core_byteenable[BE_W-1-i];
            end
        end
    end

    // Bus strobes are gated by reset so they fall the instant reset rises.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;
        retired_d  = retired_q;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        core_step  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    if (core_pc == HALT_ADDR) begin
                        state_d = HALTED;
                    end else begin
                        read       = 1'b1;
                        address    = core_pc & ALIGN_MASK;
                        byteenable = '1;
                        if (!waitrequest) begin
                            instr_d = instr_sw;
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    state_d = (core_data_read || core_data_write) ? MEM : COMMIT;
                end
                MEM: begin
                    address    = core_data_address & ALIGN_MASK;
                    byteenable = be_conv;
                    writedata  = wdata_sw;
                    write      = core_data_write;
                    read       = core_data_read & ~core_data_write;
                    if (!waitrequest) begin
                        if (read) begin
                            rdata_d = load_sw;
                        end
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    if (clk_enable) begin
                        core_step = 1'b1;
                        retired_d = retired_q + PERF_W'(1);
                        state_d   = FETCH;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            rdata_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            retired_q <= retired_d;
        end
    end

    assign core_instr    = instr_q;
    assign core_readdata = rdata_q;
    assign retired       = retired_q;
    assign active        = (state_q != HALTED);
endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Directed bench for mips_bus_sequencer: fetch, load with wait states, store, stall, halt, reset.
module tb_mips_bus_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] core_pc;
    logic [31:0] core_instr;
    logic [31:0] core_data_address;
    logic        core_data_read;
    logic        core_data_write;
    logic [3:0]  core_byteenable;
    logic [31:0] core_writedata;
    logic [31:0] core_readdata;
    logic        core_step;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        active;
    logic [31:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    mips_bus_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .clk_enable        (clk_enable),
        .core_pc           (core_pc),
        .core_instr        (core_instr),
        .core_data_address (core_data_address),
        .core_data_read    (core_data_read),
        .core_data_write   (core_data_write),
        .core_byteenable   (core_byteenable),
        .core_writedata    (core_writedata),
        .core_readdata     (core_readdata),
        .core_step         (core_step),
        .address           (address),
        .read              (read),
        .write             (write),
        .byteenable        (byteenable),
        .writedata         (writedata),
        .readdata          (readdata),
        .waitrequest       (waitrequest),
        .active            (active),
        .retired           (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic bad;
        reset = 1'b1; clk_enable = 1'b1; core_pc = 32'hBFC0_0000;
        core_data_address = '0; core_data_read = 1'b0; core_data_write = 1'b0;
        core_byteenable = '0; core_writedata = '0;
        readdata = 32'h0000_0824; waitrequest = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_step", core_step, 0);
        check("rst_active", active, 1);
        check("rst_instr", core_instr, 0);
        check("rst_rdata", core_readdata, 0);
        check("rst_retired", retired, 0);
        check("rst_addr", address, 0);
        check("rst_be", byteenable, 0);

        // ALU instruction: FETCH, EXEC, COMMIT
        @(negedge clk); reset = 1'b0; #1;
        check("f1_read", read, 1);
        check("f1_addr", address, 32'hBFC0_0000);
        check("f1_be", byteenable, 4'hF);
        check("f1_write", write, 0);
        @(negedge clk); #1;
        check("e1_instr", core_instr, 32'h2408_0000);
        check("e1_read", read, 0);
        check("e1_step", core_step, 0);
        @(negedge clk); #1;
        check("c1_step", core_step, 1);

        // Load with three wait states
        @(negedge clk);
        core_pc = 32'hBFC0_0004; readdata = 32'h0000_008C;
        core_data_read = 1'b1; core_data_address = 32'h0000_1006; core_byteenable = 4'b0011;
        #1;
        check("f2_retired", retired, 1);
        check("f2_step", core_step, 0);
        check("f2_addr", address, 32'hBFC0_0004);
        @(negedge clk); #1;
        check("e2_instr", core_instr, 32'h8C00_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            waitrequest = 1'b1; readdata = 32'hAABB_CCDD;
            #1;
            check("m2_wait_read", read, 1);
            check("m2_wait_write", write, 0);
            check("m2_wait_addr", address, 32'h0000_1004);
            check("m2_wait_be", byteenable, 4'b1100);
            check("m2_wait_rdata", core_readdata, 0);
            check("m2_wait_step", core_step, 0);
        end
        @(negedge clk); waitrequest = 1'b0; #1;
        check("m2_done_read", read, 1);
        check("m2_done_addr", address, 32'h0000_1004);
        @(negedge clk); #1;
        check("c2_step", core_step, 1);
        check("c2_rdata", core_readdata, 32'hDDCC_BBAA);
        check("c2_instr", core_instr, 32'h8C00_0000);

        // Store, with the load flag also raised: write must win
        @(negedge clk);
        core_pc = 32'hBFC0_0008; readdata = 32'h0000_00AC;
        core_data_read = 1'b1; core_data_write = 1'b1;
        core_data_address = 32'h0000_2003; core_byteenable = 4'b1111;
        core_writedata = 32'h1122_3344;
        #1;
        check("f3_retired", retired, 2);
        @(negedge clk); #1;
        check("e3_write", write, 0);
        @(negedge clk); #1;
        check("m3_write", write, 1);
        check("m3_read", read, 0);
        check("m3_wdata", writedata, 32'h4433_2211);
        check("m3_be", byteenable, 4'hF);
        check("m3_addr", address, 32'h0000_2000);

        // COMMIT stalled by clk_enable for five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); clk_enable = 1'b0; #1;
            check("stall_step", core_step, 0);
            check("stall_retired", retired, 2);
        end
        @(negedge clk); clk_enable = 1'b1; #1;
        check("c3_step", core_step, 1);
        check("c3_rdata_kept", core_readdata, 32'hDDCC_BBAA);

        // Halt at PC 0
        @(negedge clk);
        core_pc = 32'h0; core_data_read = 1'b0; core_data_write = 1'b0; #1;
        check("h_retired", retired, 3);
        check("h_fetch_read", read, 0);
        check("h_fetch_active", active, 1);
        @(negedge clk); #1;
        check("h_active", active, 0);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (active || read || write || core_step) bad = 1'b1;
        end
        check("h_stays_halted", bad, 0);
        check("h_retired_hold", retired, 3);

        // Reset in the middle of a stalled store
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        core_pc = 32'hBFC0_0000; readdata = 32'h0000_00AC;
        core_data_write = 1'b1; core_data_address = 32'h0000_3000; #1;
        check("r_fetch_read", read, 1);
        @(negedge clk); #1;
        @(negedge clk); waitrequest = 1'b1; #1;
        check("r_mem_write", write, 1);
        #2 reset = 1'b1;
        #1;
        check("r_async_write", write, 0);
        check("r_async_read", read, 0);
        @(negedge clk); reset = 1'b0; waitrequest = 1'b0; core_data_write = 1'b0; #1;
        check("r_active", active, 1);
        check("r_retired", retired, 0);
        check("r_refetch_read", read, 1);
        check("r_refetch_addr", address, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
